// File: rtl/peri_pkg.sv
// Shared definitions for the peri readout chain: default geometry and the
// readout word layout (node index in the MSBs, FIFO payload in the LSBs).
package peri_pkg;

  localparam int PERI_DATA_W = 28;
  localparam int PERI_NODES  = 8;
  localparam int PERI_ID_W   = $clog2(PERI_NODES);
  localparam int PERI_WORD_W = PERI_ID_W + PERI_DATA_W;

  typedef struct packed {
    logic [PERI_ID_W-1:0]   id;
    logic [PERI_DATA_W-1:0] data;
  } peri_word_t;

endpackage

// File: rtl/peri_rr_arbiter.sv
// Round-robin grant over a request vector: the first requester at or after
// ptr (wrapping) wins, and the pointer advances to just past the winner.
module peri_rr_arbiter
  import peri_pkg::*;
#(
  parameter int NODES = PERI_NODES,
  parameter int ID_W  = $clog2(NODES)
) (
  input  logic [NODES-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  input  logic             en_i,
  output logic [NODES-1:0] gnt_o,
  output logic [ID_W-1:0]  gnt_idx_o,
  output logic             gnt_vld_o,
  output logic [ID_W-1:0]  ptr_nxt_o
);

  int cand;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    ptr_nxt_o = ptr_i;
    cand      = 0;
    for (int k = 0; k < NODES; k++) begin
      cand = (int'(ptr_i) + k) % NODES;
      if (en_i && !gnt_vld_o && req_i[cand]) begin
        gnt_vld_o   = 1'b1;
        gnt_idx_o   = cand[ID_W-1:0];
        gnt_o[cand] = 1'b1;
        ptr_nxt_o   = (cand == NODES - 1) ? '0 : ID_W'(cand + 1);
      end
    end
  end

endmodule

// File: rtl/peri_readout_arbiter.sv
// Merges hit words from the peri node FIFOs into one tagged readout stream
// through a 2-entry output queue, counting words delivered downstream.
module peri_readout_arbiter
  import peri_pkg::*;
#(
  parameter int NODES  = PERI_NODES,
  parameter int DATA_W = PERI_DATA_W,
  parameter int ID_W   = $clog2(NODES),
  parameter int CNT_W  = 16
) (
  input  logic                   clk_40MHz,
  input  logic                   rst,
  input  logic                   readout_en,
  input  logic [NODES-1:0]       node_empty,
  input  logic [NODES*DATA_W-1:0] node_data,
  output logic [NODES-1:0]       shakehands_next,
  output logic [ID_W+DATA_W-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CNT_W-1:0]       word_cnt,
  input  logic                   cnt_clr,
  output logic                   busy
);

  localparam int WORD_W = ID_W + DATA_W;

  logic [1:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] head_q, head_d;
  logic [WORD_W-1:0] tail_q, tail_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;

  logic              pop, push, space, arb_en;
  logic [NODES-1:0]  grant;
  logic [ID_W-1:0]   gnt_idx;
  logic [WORD_W-1:0] push_word;

  assign out_valid = (cnt_q != 2'd0);
  assign pop       = out_valid & out_ready;
  // A full queue can still accept a word when its head leaves this cycle.
  assign space     = (cnt_q != 2'd2) | pop;
  assign arb_en    = readout_en & space & ~rst;

  peri_rr_arbiter #(
    .NODES (NODES),
    .ID_W  (ID_W)
  ) u_rr (
    .req_i     (~node_empty),
    .ptr_i     (ptr_q),
    .en_i      (arb_en),
    .gnt_o     (grant),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (push),
    .ptr_nxt_o (ptr_d)
  );

  assign push_word       = {gnt_idx, node_data[gnt_idx*DATA_W +: DATA_W]};
  assign shakehands_next = grant;
  assign out_data        = head_q;
  assign word_cnt        = wcnt_q;
  assign busy            = ~rst & ((cnt_q != 2'd0) | (readout_en & ~(&node_empty)));

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = push_word;
        else               tail_d = push_word;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = push_word;
        end else begin
          head_d = tail_q;
          tail_d = push_word;
        end
      end
      default: ;
    endcase
  end

  // Clear wins over a same-cycle transfer; the count sticks at all-ones.
  always_comb begin
    wcnt_d = wcnt_q;
    if (cnt_clr)                   wcnt_d = '0;
    else if (pop && wcnt_q != '1)  wcnt_d = wcnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_40MHz) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
      ptr_q  <= '0;
      wcnt_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      ptr_q  <= ptr_d;
      wcnt_q <= wcnt_d;
    end
  end

endmodule

// File: tb/tb_peri_readout_arbiter.sv
// Directed bench for peri_readout_arbiter: emulated FWFT node FIFOs feed the
// design and a scoreboard checks every word delivered downstream.
module tb_peri_readout_arbiter;

  localparam int NODES  = 8;
  localparam int DATA_W = 28;
  localparam int ID_W   = 3;
  localparam int CNT_W  = 16;
  localparam int WORD_W = ID_W + DATA_W;

  logic                    clk_40MHz = 1'b0;
  logic                    rst;
  logic                    readout_en;
  logic [NODES-1:0]        node_empty;
  logic [NODES*DATA_W-1:0] node_data;
  logic [NODES-1:0]        shakehands_next;
  logic [WORD_W-1:0]       out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [CNT_W-1:0]        word_cnt;
  logic                    cnt_clr;
  logic                    busy;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] node_q [NODES][$];
  logic [WORD_W-1:0] sb [$];
  int                gnt_log [$];

  always #12 clk_40MHz = ~clk_40MHz;

  peri_readout_arbiter #(
    .NODES  (NODES),
    .DATA_W (DATA_W),
    .ID_W   (ID_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_40MHz       (clk_40MHz),
    .rst             (rst),
    .readout_en      (readout_en),
    .node_empty      (node_empty),
    .node_data       (node_data),
    .shakehands_next (shakehands_next),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .word_cnt        (word_cnt),
    .cnt_clr         (cnt_clr),
    .busy            (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NODES; i++) begin
      node_empty[i] = (node_q[i].size() == 0);
      node_data[i*DATA_W +: DATA_W] = node_empty[i] ? '0 : node_q[i][0];
    end
  endtask

  task automatic load_exp(input int id, input logic [DATA_W-1:0] d, input bit exp_out);
    node_q[id].push_back(d);
    if (exp_out) sb.push_back({ID_W'(id), d});
    refresh();
  endtask

  // One clock: sample strobes and the transfer at the falling edge, then
  // retire popped node words just after the rising edge.
  task automatic cyc();
    logic [NODES-1:0]  strobe;
    logic [WORD_W-1:0] expw;
    @(negedge clk_40MHz);
    strobe = shakehands_next;
    if (!rst && out_valid && out_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_extra_word: observed %0h expected no word", out_data);
      end
      if (sb.size() != 0) begin
        expw = sb.pop_front();
        check("sb_word", out_data, expw);
      end
    end
    @(posedge clk_40MHz);
    #1;
    for (int i = 0; i < NODES; i++) begin
      if (strobe[i]) begin
        gnt_log.push_back(i);
        if (node_q[i].size() > 0) node_q[i].delete(0);
      end
    end
    refresh();
    #1;
  endtask

  task automatic run_idle(input int max_cyc);
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < max_cyc && !idle; n++) begin
      if (sb.size() == 0 && (&node_empty) && !out_valid) idle = 1'b1;
      else cyc();
    end
    idle = (sb.size() == 0 && (&node_empty) && !out_valid);
    checks++;
    assert (idle) else begin
      errors++;
      $error("FAIL drain_timeout: observed %0d words pending expected 0", sb.size());
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; readout_en = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    refresh();
    repeat (2) cyc();
    check("rst_strobe", shakehands_next, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_cnt", word_cnt, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // single node
    readout_en = 1'b1; out_ready = 1'b1;
    load_exp(3, 28'h0ABCDEF, 1'b1);
    #1;
    check("single_strobe", shakehands_next, 8'b0000_1000);
    check("single_busy", busy, 1);
    cyc();
    check("single_strobe_off", shakehands_next, 0);
    check("single_valid", out_valid, 1);
    check("single_data", out_data, {3'd3, 28'h0ABCDEF});
    cyc();
    check("single_cnt", word_cnt, 1);

    // fairness from ptr=0
    load_exp(7, 28'h0700007, 1'b1);
    run_idle(20);
    for (int i = 0; i < NODES; i++) load_exp(i, 28'h0100000 + 28'(i), 1'b1);
    load_exp(0, 28'h0200000, 1'b1);
    gnt_log.delete();
    repeat (9) cyc();
    check("fair_ngnt", gnt_log.size(), 9);
    for (int k = 0; k < 9; k++) check("fair_gnt", gnt_log[k], k % NODES);
    run_idle(20);
    check("fair_cnt", word_cnt, 11);

    // backpressure, ptr=1
    out_ready = 1'b0;
    for (int k = 1; k <= NODES; k++) load_exp(k % NODES, 28'h0300000 + 28'(k % NODES), 1'b1);
    gnt_log.delete();
    repeat (4) cyc();
    check("bp_ngnt", gnt_log.size(), 2);
    check("bp_gnt0", gnt_log[0], 1);
    check("bp_gnt1", gnt_log[1], 2);
    check("bp_strobe", shakehands_next, 0);
    check("bp_valid", out_valid, 1);
    check("bp_head", out_data, {3'd1, 28'h0300001});
    cyc();
    check("bp_frozen", out_data, {3'd1, 28'h0300001});
    out_ready = 1'b1;
    repeat (8) cyc();
    check("bp_drained", sb.size(), 0);
    check("bp_valid_off", out_valid, 0);
    check("bp_cnt", word_cnt, 19);

    // wrap and skip from ptr=6
    load_exp(5, 28'h0500005, 1'b1);
    run_idle(20);
    load_exp(6, 28'h0666666, 1'b1);
    load_exp(1, 28'h0111111, 1'b1);
    gnt_log.delete();
    run_idle(20);
    check("wrap_gnt0", gnt_log[0], 6);
    check("wrap_gnt1", gnt_log[1], 1);
    load_exp(2, 28'h0222220, 1'b1);
    load_exp(1, 28'h0111110, 1'b1);
    gnt_log.delete();
    run_idle(20);
    check("wrap_ptr2", gnt_log[0], 2);
    check("wrap_cnt", word_cnt, 24);

    // readout_en low with a full queue
    out_ready = 1'b0;
    for (int i = 3; i <= 6; i++) load_exp(i, 28'h0400000 + 28'(i), 1'b1);
    gnt_log.delete();
    repeat (3) cyc();
    check("en_fill", gnt_log.size(), 2);
    readout_en = 1'b0;
    #1;
    check("en_strobe", shakehands_next, 0);
    check("en_busy_full", busy, 1);
    out_ready = 1'b1;
    gnt_log.delete();
    cyc();
    check("en_valid1", out_valid, 1);
    check("en_busy1", busy, 1);
    cyc();
    check("en_valid0", out_valid, 0);
    check("en_nogrant", gnt_log.size(), 0);
    readout_en = 1'b1;
    run_idle(20);
    check("en_cnt", word_cnt, 28);

    // counter clear, saturation, clear beating a transfer
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    check("clr_idle", word_cnt, 0);
    for (int k = 0; k < 65535; k++) begin
      load_exp(0, 28'(k), 1'b1);
      cyc();
    end
    run_idle(20);
    check("sat_reach", word_cnt, 16'hFFFF);
    load_exp(2, 28'h0222222, 1'b1);
    run_idle(20);
    check("sat_hold", word_cnt, 16'hFFFF);
    load_exp(3, 28'h0333333, 1'b1);
    cyc();
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    check("clr_xfer", word_cnt, 0);
    check("clr_xfer_valid", out_valid, 0);

    // reset mid-stream
    load_exp(7, 28'h0777777, 1'b1);
    run_idle(20);
    check("pre_rst_cnt", word_cnt, 1);
    out_ready = 1'b0;
    load_exp(4, 28'h0444444, 1'b0);
    load_exp(5, 28'h0555555, 1'b0);
    repeat (2) cyc();
    check("pre_rst_valid", out_valid, 1);
    load_exp(6, 28'h0666660, 1'b0);
    rst = 1'b1; out_ready = 1'b1;
    #1;
    check("rst_cycle_strobe", shakehands_next, 0);
    cyc();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_cnt", word_cnt, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_strobe", shakehands_next, 0);
    check("mid_rst_node6", node_q[6].size(), 1);
    rst = 1'b0;
    sb.push_back({3'd6, 28'h0666660});
    run_idle(20);
    check("post_rst_cnt", word_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
